// File: rtl/cosim_stim_pkg.sv
// Shared types and helpers for the co-simulation stimulus sequencer.
// Phase encodings double as the externally visible o_phase value.
package cosim_stim_pkg;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_RST1 = 3'd1,
      PH_GAP1 = 3'd2,
      PH_RAND = 3'd3,
      PH_RST2 = 3'd4,
      PH_GAP2 = 3'd5,
      PH_DIR  = 3'd6,
      PH_DONE = 3'd7
   } phase_e;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam int          CNT_W     = 16;

   function automatic logic [31:0] lfsr_next(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/cosim_stim_sequencer_lfsr.sv
// 32-bit Galois LFSR (right shift) with synchronous reload.
// Reset and load both restore the seed; load wins over advance.
module cosim_lfsr32
   import cosim_stim_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [31:0] i_seed,
   input  logic        i_adv,
   output logic [31:0] o_q
);

   logic [31:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_q <= i_seed;
      end else if (i_adv) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/cosim_stim_sequencer.sv
// Campaign sequencer driving DUT reset/stimulus and a compare strobe.
// Outputs are registered from the next-state view of the FSM.
module cosim_stim_sequencer
   import cosim_stim_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter int          NUM_RANDOM   = 1000,
   parameter int          HOLD         = 2,
   parameter int          RESET_CYCLES = 3,
   parameter logic [31:0] SEED         = 32'h0000_0001,
   parameter logic [31:0] DIRECTED     = 32'habcd_efab
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic             o_dut_rst,
   output logic [WIDTH-1:0] o_stim,
   output logic             o_sample,
   output logic [CNT_W-1:0] o_sample_cnt,
   output logic [2:0]       o_phase,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [31:0] LP_SEED =
      (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [31:0] LP_RST_LAST  = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] LP_HOLD_LAST = 32'(HOLD - 1);
   localparam logic [31:0] LP_SLOT_LAST = 32'(NUM_RANDOM - 1);
   localparam logic [WIDTH-1:0] LP_DIR  = DIRECTED[WIDTH-1:0];
   localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

   phase_e           r_phase;
   phase_e           w_phase_n;
   logic [31:0]      r_hold;
   logic [31:0]      w_hold_n;
   logic [31:0]      r_slot;
   logic [31:0]      w_slot_n;
   logic             w_load;
   logic             w_adv;
   logic [31:0]      w_lfsr_q;
   logic [31:0]      w_lfsr_n;

   logic             r_dut_rst;
   logic [WIDTH-1:0] r_stim;
   logic             r_sample;
   logic [CNT_W-1:0] r_sample_cnt;
   logic             r_busy;
   logic             r_done;

   logic             w_dut_rst_n;
   logic [WIDTH-1:0] w_stim_n;
   logic             w_sample_n;
   logic             w_busy_n;
   logic             w_done_n;

   cosim_lfsr32 u_lfsr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_load),
      .i_seed (LP_SEED),
      .i_adv  (w_adv),
      .o_q    (w_lfsr_q)
   );

   always_comb begin
      w_phase_n = r_phase;
      w_hold_n  = r_hold;
      w_slot_n  = r_slot;
      w_load    = 1'b0;
      w_adv     = 1'b0;
      unique case (r_phase)
         PH_IDLE, PH_DONE: begin
            if (i_start) begin
               w_phase_n = PH_RST1;
               w_hold_n  = 32'd0;
               w_load    = 1'b1;
            end
         end
         PH_RST1, PH_RST2: begin
            if (r_hold == LP_RST_LAST) begin
               w_hold_n = 32'd0;
               if (r_phase == PH_RST1) w_phase_n = PH_GAP1;
               else                    w_phase_n = PH_GAP2;
            end else begin
               w_hold_n = r_hold + 32'd1;
            end
         end
         PH_GAP1: begin
            w_hold_n = 32'd0;
            w_slot_n = 32'd0;
            if (NUM_RANDOM == 0) w_phase_n = PH_RST2;
            else                 w_phase_n = PH_RAND;
         end
         PH_RAND: begin
            if (r_hold == LP_HOLD_LAST) begin
               w_hold_n = 32'd0;
               w_adv    = 1'b1;
               if (r_slot == LP_SLOT_LAST) w_phase_n = PH_RST2;
               else w_slot_n = r_slot + 32'd1;
            end else begin
               w_hold_n = r_hold + 32'd1;
            end
         end
         PH_GAP2: begin
            w_phase_n = PH_DIR;
            w_hold_n  = 32'd0;
         end
         PH_DIR: begin
            if (r_hold == LP_HOLD_LAST) begin
               w_phase_n = PH_DONE;
               w_hold_n  = 32'd0;
            end else begin
               w_hold_n = r_hold + 32'd1;
            end
         end
         default: w_phase_n = PH_IDLE;
      endcase
   end

   // Value the LFSR register will hold after this edge.
   assign w_lfsr_n = w_adv ? lfsr_next(w_lfsr_q) : w_lfsr_q;

   always_comb begin
      w_stim_n = '0;
      unique case (w_phase_n)
         PH_RAND:         w_stim_n = w_lfsr_n[WIDTH-1:0];
         PH_DIR, PH_DONE: w_stim_n = LP_DIR;
         default:         w_stim_n = '0;
      endcase
   end

   assign w_dut_rst_n = (w_phase_n == PH_IDLE) ||
                        (w_phase_n == PH_RST1) ||
                        (w_phase_n == PH_RST2);
   assign w_sample_n =
      (((w_phase_n == PH_RST1) || (w_phase_n == PH_RST2)) &&
       (w_hold_n == LP_RST_LAST)) ||
      (((w_phase_n == PH_RAND) || (w_phase_n == PH_DIR)) &&
       (w_hold_n == LP_HOLD_LAST));
   assign w_busy_n = (w_phase_n != PH_IDLE) &&
                     (w_phase_n != PH_DONE);
   assign w_done_n = (w_phase_n == PH_DONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase      <= PH_IDLE;
         r_hold       <= 32'd0;
         r_slot       <= 32'd0;
         r_dut_rst    <= 1'b1;
         r_stim       <= '0;
         r_sample     <= 1'b0;
         r_sample_cnt <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_phase   <= w_phase_n;
         r_hold    <= w_hold_n;
         r_slot    <= w_slot_n;
         r_dut_rst <= w_dut_rst_n;
         r_stim    <= w_stim_n;
         r_sample  <= w_sample_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         if (w_load) begin
            r_sample_cnt <= '0;
         end else if (r_sample && (r_sample_cnt != '1)) begin
            r_sample_cnt <= r_sample_cnt + LP_CNT_ONE;
         end
      end
   end

   assign o_dut_rst    = r_dut_rst;
   assign o_stim       = r_stim;
   assign o_sample     = r_sample;
   assign o_sample_cnt = r_sample_cnt;
   assign o_phase      = r_phase;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_cosim_stim_sequencer.sv
// Directed bench for cosim_stim_sequencer (default and NUM_RANDOM=0).
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_cosim_stim_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start0;

   logic        dut_rst;
   logic [31:0] stim;
   logic        sample;
   logic [15:0] sample_cnt;
   logic [2:0]  phase;
   logic        busy;
   logic        done;

   logic        dut_rst0;
   logic [31:0] stim0;
   logic        sample0;
   logic [15:0] sample_cnt0;
   logic [2:0]  phase0;
   logic        busy0;
   logic        done0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cosim_stim_sequencer u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .o_dut_rst    (dut_rst),
      .o_stim       (stim),
      .o_sample     (sample),
      .o_sample_cnt (sample_cnt),
      .o_phase      (phase),
      .o_busy       (busy),
      .o_done       (done)
   );

   cosim_stim_sequencer #(.NUM_RANDOM(0)) u_dut0 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start0),
      .o_dut_rst    (dut_rst0),
      .o_stim       (stim0),
      .o_sample     (sample0),
      .o_sample_cnt (sample_cnt0),
      .o_phase      (phase0),
      .o_busy       (busy0),
      .o_done       (done0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      start0 = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_phase(input logic [2:0] ph,
                             input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (phase === ph) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      start0 = 1'b0;
      repeat (5) step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_state: phase=%0d busy=%b done=%b, want 0/0/0",
                     phase, busy, done);
         end
         n_checks++;
         if (dut_rst !== 1'b1 || stim !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: dut_rst=%b stim=%h, want 1/0",
                     dut_rst, stim);
         end
         n_checks++;
         if (sample !== 1'b0 || sample_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_sample: sample=%b cnt=%0d, want 0/0",
                     sample, sample_cnt);
         end
      end
   endtask

   task automatic test_default_campaign();
      int cyc = 0;
      int ns = 0;
      do_reset();
      pulse_start();
      n_checks++;
      if (phase !== 3'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: phase=%0d busy=%b, want 1/1",
                  phase, busy);
      end
      while (busy === 1'b1 && cyc < 3000) begin
         cyc++;
         if (sample === 1'b1) ns++;
         step();
      end
      n_checks++;
      if (cyc != 2010) begin
         n_fail++;
         $display("FAIL busy_len: got %0d, want 2010", cyc);
      end
      n_checks++;
      if (done !== 1'b1 || phase !== 3'd7) begin
         n_fail++;
         $display("FAIL done_state: done=%b phase=%0d, want 1/7",
                  done, phase);
      end
      n_checks++;
      if (sample_cnt !== 16'd1003) begin
         n_fail++;
         $display("FAIL sample_cnt: got %0d, want 1003", sample_cnt);
      end
      n_checks++;
      if (ns != 1003) begin
         n_fail++;
         $display("FAIL sample_pulses: got %0d, want 1003", ns);
      end
      repeat (3) step();
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd1003) begin
         n_fail++;
         $display("FAIL done_sticky: done=%b busy=%b cnt=%0d, want 1/0/1003",
                  done, busy, sample_cnt);
      end
   endtask

   task automatic test_lfsr_sequence();
      logic [31:0] exp_s [6] = '{32'h0000_0001, 32'h0000_0001,
                                 32'h8020_0003, 32'h8020_0003,
                                 32'hC030_0002, 32'hC030_0002};
      logic        exp_p [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit ok;
      do_reset();
      pulse_start();
      wait_phase(3'd3, 50, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rand_reach: phase=%0d, want 3 within 50", phase);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (stim !== exp_s[i] || sample !== exp_p[i]) begin
            n_fail++;
            $display("FAIL lfsr_vec%0d: stim=%h sample=%b, want %h/%b",
                     i, stim, sample, exp_s[i], exp_p[i]);
         end
         n_checks++;
         if (dut_rst !== 1'b0 || phase !== 3'd3) begin
            n_fail++;
            $display("FAIL rand_ctrl%0d: dut_rst=%b phase=%0d, want 0/3",
                     i, dut_rst, phase);
         end
         step();
      end
   endtask

   task automatic test_directed_boundaries();
      logic [2:0] prev_ph = 3'd0;
      logic       prev_rst = 1'b1;
      int seen_g1 = 0;
      int seen_g2 = 0;
      int dir_n = 0;
      int cyc = 0;
      do_reset();
      pulse_start();
      while (phase !== 3'd7 && cyc < 3000) begin
         if (phase === 3'd2 || phase === 3'd5) begin
            if (phase === 3'd2) seen_g1++;
            else seen_g2++;
            n_checks++;
            if (dut_rst !== 1'b0 || prev_rst !== 1'b1 ||
                prev_ph !== phase - 3'd1 || stim !== 32'h0 ||
                sample !== 1'b0) begin
               n_fail++;
               $display("FAIL gap%0d_edge: rst=%b prev_rst=%b prev_ph=%0d stim=%h smp=%b",
                        phase, dut_rst, prev_rst, prev_ph, stim, sample);
            end
         end
         if (phase === 3'd6) begin
            dir_n++;
            n_checks++;
            if (stim !== 32'habcdefab || sample !== (dir_n == 2)) begin
               n_fail++;
               $display("FAIL dir_vec%0d: stim=%h sample=%b, want abcdefab/%b",
                        dir_n, stim, sample, dir_n == 2);
            end
         end
         prev_ph = phase;
         prev_rst = dut_rst;
         cyc++;
         step();
      end
      n_checks++;
      if (seen_g1 != 1 || seen_g2 != 1 || dir_n != 2) begin
         n_fail++;
         $display("FAIL phase_counts: gap1=%0d gap2=%0d dir=%0d, want 1/1/2",
                  seen_g1, seen_g2, dir_n);
      end
      n_checks++;
      if (stim !== 32'habcdefab || dut_rst !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_hold: stim=%h rst=%b done=%b, want abcdefab/0/1",
                  stim, dut_rst, done);
      end
   endtask

   task automatic test_num_random_zero();
      int cyc = 0;
      int seen_rand = 0;
      do_reset();
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      while (busy0 === 1'b1 && cyc < 100) begin
         cyc++;
         if (phase0 === 3'd3) seen_rand++;
         step();
      end
      n_checks++;
      if (cyc != 10 || seen_rand != 0) begin
         n_fail++;
         $display("FAIL nr0_busy: busy=%0d rand=%0d, want 10/0",
                  cyc, seen_rand);
      end
      n_checks++;
      if (sample_cnt0 !== 16'd3 || done0 !== 1'b1) begin
         n_fail++;
         $display("FAIL nr0_done: cnt=%0d done=%b, want 3/1",
                  sample_cnt0, done0);
      end
      n_checks++;
      if (stim0 !== 32'habcdefab) begin
         n_fail++;
         $display("FAIL nr0_stim: got %h, want abcdefab", stim0);
      end
   endtask

   task automatic test_abort_restart();
      bit ok;
      int rs = 0;
      int cyc = 0;
      do_reset();
      pulse_start();
      wait_phase(3'd3, 50, ok);
      while (rs < 500 && cyc < 3000) begin
         if (phase === 3'd3 && sample === 1'b1) rs++;
         cyc++;
         step();
      end
      n_checks++;
      if (rs != 500 || phase !== 3'd3) begin
         n_fail++;
         $display("FAIL abort_reach: slots=%0d phase=%0d, want 500/3",
                  rs, phase);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (phase !== 3'd0 || dut_rst !== 1'b1 || stim !== 32'h0 ||
          sample !== 1'b0 || sample_cnt !== 16'd0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: ph=%0d rst=%b stim=%h smp=%b cnt=%0d bsy=%b dn=%b",
                  phase, dut_rst, stim, sample, sample_cnt, busy, done);
      end
      rst = 1'b0;
      step();
      pulse_start();
      wait_phase(3'd3, 50, ok);
      n_checks++;
      if (!ok || stim !== 32'h0000_0001 || sample !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_seed: stim=%h smp=%b, want 00000001/0",
                  stim, sample);
      end
      step();
      step();
      n_checks++;
      if (stim !== 32'h8020_0003) begin
         n_fail++;
         $display("FAIL restart_vec1: got %h, want 80200003", stim);
      end
   endtask

   task automatic test_start_held();
      logic [31:0] exp_s [6] = '{32'h0000_0001, 32'h0000_0001,
                                 32'h8020_0003, 32'h8020_0003,
                                 32'hC030_0002, 32'hC030_0002};
      for (int run = 0; run < 2; run++) begin
         int cyc = 0;
         int k = 0;
         if (run == 0) do_reset();
         start = 1'b1;
         step();
         if (run == 1) start = 1'b0;
         n_checks++;
         if (phase !== 3'd1 || sample_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL run%0d_start: phase=%0d cnt=%0d, want 1/0",
                     run, phase, sample_cnt);
         end
         while (busy === 1'b1 && cyc < 3000) begin
            if (phase === 3'd3 && k < 6) begin
               n_checks++;
               if (stim !== exp_s[k]) begin
                  n_fail++;
                  $display("FAIL run%0d_vec%0d: got %h, want %h",
                           run, k, stim, exp_s[k]);
               end
               k++;
            end
            cyc++;
            step();
         end
         start = 1'b0;
         n_checks++;
         if (cyc != 2010 || k != 6) begin
            n_fail++;
            $display("FAIL run%0d_len: busy=%0d vecs=%0d, want 2010/6",
                     run, cyc, k);
         end
         repeat (3) step();
         n_checks++;
         if (phase !== 3'd7 || busy !== 1'b0 || sample_cnt !== 16'd1003) begin
            n_fail++;
            $display("FAIL run%0d_single: ph=%0d busy=%b cnt=%0d, want 7/0/1003",
                     run, phase, busy, sample_cnt);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start0 = 1'b0;
      test_reset();
      test_default_campaign();
      test_lfsr_sequence();
      test_directed_boundaries();
      test_num_random_zero();
      test_abort_restart();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: timeout reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
